// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Boot loader: receives a length-prefixed big-endian 16-bit word
//            image over valid/ready, writes it to instruction memory from
//            address 0, then releases the CPU reset.
//            Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [7:0]        RxData,
   input  logic              RxValid,
   output logic              RxReady,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [15:0]       MemData,
   output logic              MemRW,
   output logic              CpuReset,
   output logic              Done,
   output logic              Error
);

   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DAT_HI = 3'd2,
      DAT_LO = 3'd3,
      WRITE  = 3'd4,
      CSUM   = 3'd5,
      RUN    = 3'd6,
      ERR    = 3'd7
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CSUM;
`else
   localparam state_t END_STATE = RUN;
`endif

   state_t            state;
   state_t            state_next;
   logic [15:0]       count;
   logic [15:0]       word;
   logic [ADDR_W:0]   written;
   logic [ADDR_W-1:0] addr;

   logic              rx_state;
   logic              accept;
   logic [15:0]       count_new;
   logic [ADDR_W:0]   written_inc;
   logic              last_word;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum;
   logic [7:0]        csum_total;
   assign csum_total = sum + RxData;
   assign rx_state   = (state == LEN_HI) || (state == LEN_LO) || (state == DAT_HI) ||
                       (state == DAT_LO) || (state == CSUM);
`else
   assign rx_state   = (state == LEN_HI) || (state == LEN_LO) || (state == DAT_HI) ||
                       (state == DAT_LO);
`endif

   assign RxReady     = Reset && rx_state;
   assign accept      = RxValid && RxReady;
   // The low length byte is decided on in the same cycle it arrives.
   assign count_new   = {count[15:8], RxData};
   assign written_inc = written + (ADDR_W+1)'(1);
   assign last_word   = (32'(written_inc) == 32'(count));
   assign MemAddr     = addr;
   assign MemData     = word;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= LEN_HI;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      MemRW      = 1'b0;
      CpuReset   = 1'b0;
      Done       = 1'b0;
      Error      = 1'b0;
      case (state)
         LEN_HI: if (accept) state_next = LEN_LO;
         LEN_LO: begin
            if (accept) begin
               if (32'(count_new) > MAX_WORDS) begin
                  state_next = ERR;
               end else if (count_new == 16'd0) begin
                  state_next = END_STATE;
               end else begin
                  state_next = DAT_HI;
               end
            end
         end
         DAT_HI: if (accept) state_next = DAT_LO;
         DAT_LO: if (accept) state_next = WRITE;
         WRITE: begin
            MemRW      = 1'b1;
            state_next = last_word ? END_STATE : DAT_HI;
         end
         CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) state_next = (csum_total == 8'd0) ? RUN : ERR;
`else
            state_next = LEN_HI;
`endif
         end
         RUN: begin
            CpuReset = 1'b1;
            Done     = 1'b1;
         end
         ERR: Error = 1'b1;
         default: state_next = LEN_HI;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         count   <= '0;
         word    <= '0;
         written <= '0;
         addr    <= '0;
      end else begin
         if (accept) begin
            case (state)
               LEN_HI: count[15:8] <= RxData;
               LEN_LO: count[7:0]  <= RxData;
               DAT_HI: word[15:8]  <= RxData;
               DAT_LO: word[7:0]   <= RxData;
               default: ;
            endcase
         end
         // Address wraps after the final word of a full-size image; no write follows.
         if (state == WRITE) begin
            addr    <= addr + ADDR_W'(1);
            written <= written_inc;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         sum <= '0;
      end else if (accept && (state != CSUM)) begin
         sum <= sum + RxData;
      end
   end
`endif

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader that writes program memory for the CPU. It accepts a byte stream (length header, then big-endian 16-bit instruction words) over a valid/ready handshake. It writes each assembled word into instruction memory at consecutive addresses starting at 0. It holds the CPU in reset until the whole image has been written, then releases it so execution starts at address 0.

## Interface
Parameters:
- ADDR_W, 8, memory address width; the maximum image size is 2^ADDR_W words.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- RxData  input  8  incoming byte.
- RxValid  input  1  RxData is valid this cycle.
- RxReady  output  1  loader accepts a byte this cycle.
- MemAddr  output  ADDR_W  instruction memory write address.
- MemData  output  16  instruction word to write.
- MemRW  output  1  1 = write memory this cycle; 0 = no access.
- CpuReset  output  1  active-low reset to the CPU; 0 holds the CPU in reset.
- Done  output  1  image loaded, CPU released.
- Error  output  1  load failed; CPU stays in reset.

## Operation
- A byte is accepted on a rising edge where RxValid=1, RxReady=1 and Reset=1.
- States: LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CSUM, RUN, ERR. The reset state is LEN_HI.
- RxReady = Reset AND (state is LEN_HI, LEN_LO, DAT_HI, DAT_LO or CSUM).
- LEN_HI: the accepted byte becomes Count[15:8]; go to LEN_LO.
- LEN_LO: the accepted byte becomes Count[7:0]. Then:
  - if Count > 2^ADDR_W, go to ERR;
  - else if Count = 0, go to CSUM (or RUN when the checksum is disabled);
  - else go to DAT_HI.
- DAT_HI: the accepted byte becomes Word[15:8]; go to DAT_LO.
- DAT_LO: the accepted byte becomes Word[7:0]; go to WRITE.
- WRITE (exactly one cycle):
  - MemRW=1, MemAddr=Addr, MemData=Word.
  - At the edge, Addr increments and Written increments.
  - If Written+1 = Count, go to CSUM (or RUN); else go to DAT_HI.
- CSUM and ERR behaviour is defined under Configuration.
- RUN: CpuReset=1, Done=1, RxReady=0. RUN is held until Reset; later bytes are never accepted.
- ERR: Error=1, CpuReset=0, RxReady=0. ERR is held until Reset.
- Outputs are Moore, decoded from the state and the registers. Outside WRITE: MemRW=0, MemAddr=Addr, MemData=Word.
- Widths:
  - Count is 16 bits and Written is ADDR_W+1 bits.
  - Addr wraps modulo 2^ADDR_W. With Count = 2^ADDR_W the last write goes to address 2^ADDR_W-1 and the loader then leaves the data phase, so the wrap never causes a write.

## Timing
- Reset values (state after any rising edge with Reset=0): state LEN_HI, Addr=0, Written=0, Count=0, Word=0, Sum=0, MemRW=0, CpuReset=0, Done=0, Error=0.
- RxReady is 0 while Reset=0.
- Reset during a load aborts the load. Words already written stay in memory; the next load restarts at address 0.
- Throughput: at most one byte per cycle. Each word costs at least 3 cycles (two bytes plus WRITE). RxReady is 0 during WRITE, so the sender stalls for that cycle.
- Write latency: if the low byte is accepted at edge k, MemRW=1 between edges k and k+1.
- Release latency, checksum disabled: the last WRITE ends at edge k+1, and CpuReset=1 and Done=1 from edge k+1.
- Release latency, checksum enabled: the checksum byte is accepted at edge m, and CpuReset=1 from edge m.
- RxValid may go low in any receive state; the loader waits indefinitely with no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Sum is an 8-bit register. It is cleared by reset and adds every accepted LEN and DAT byte, modulo 256.
  - The image ends with one extra byte C, accepted in CSUM.
  - If (Sum + C) mod 256 = 0, go to RUN; otherwise go to ERR.
- LOADER_CHECKSUM_EN undefined:
  - CSUM and the Sum register do not exist.
  - The data phase and the Count = 0 case go directly to RUN.
  - Error is asserted only for an oversize Count.

## Test plan
- Without checksum, stream 00 02 12 34 AB CD with RxValid held 1:
  - writes (addr 0, 1234) and (addr 1, ABCD), each with a single-cycle MemRW;
  - Done=1 and CpuReset=1 one edge after the second write;
  - RxReady=0 during each WRITE.
- With checksum, stream 00 01 50 13 then 9C (sum 0x64 + 0x9C = 0x100):
  - write (0, 5013), then RUN.
  - Repeat with final byte 9D: the write still occurs, then Error=1, CpuReset=0, Done=0.
- With ADDR_W=8, header 01 01 (257): ERR right after the header, no MemRW pulse, RxReady=0.
- Header 00 00: RUN right after the header (or after checksum byte 00) with no writes.
- Reset low for one edge after the first data byte of a 2-word load, then stream 00 01 77 88:
  - single write (0, 7788), then Done.
  - CpuReset stays 0 throughout the aborted load.
- Randomly gate RxValid low across the 00 02 12 34 AB CD image: the same writes and addresses as the first scenario, and no byte is accepted while RxValid=0.
